// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX pipeline register: stage-3 control bundle, its
// bubble encoding and the default datapath widths.
package pipe_pkg;

    localparam int BITS_DEF       = 32;
    localparam int REG_WORDS_DEF  = 32;
    localparam int OP_BITS_DEF    = 4;
    localparam int SHIFT_BITS_DEF = 5;
    localparam int CNT_BITS_DEF   = 16;
    localparam int BYTE_EN_BITS   = 4;

    typedef struct packed {
        logic                    atomic;
        logic                    sel_mem;
        logic                    check_link;
        logic                    mem_rw_;
        logic                    rw_;
        logic                    load_link_;
        logic                    alu_imm;
        logic [OP_BITS_DEF-1:0]  alu_op;
        logic [BYTE_EN_BITS-1:0] byte_en;
        logic                    halt;
    } ctl_t;

    // Inert control word: no register write, no memory write, no link load.
    localparam ctl_t CTL_BUBBLE = '{
        atomic:     1'b0,
        sel_mem:    1'b0,
        check_link: 1'b0,
        mem_rw_:    1'b1,
        rw_:        1'b1,
        load_link_: 1'b1,
        alu_imm:    1'b0,
        alu_op:     '0,
        byte_en:    4'hF,
        halt:       1'b0
    };

endpackage

// File: rtl/load_use_det.sv
// Load-use detector: stage 3 holds a register-writing load whose destination
// is a source operand of the word waiting in stage 2.
module load_use_det #(
    parameter int ADDR_LEFT = 4
) (
    input  logic             valid_s3_i,
    input  logic             valid_s2_i,
    input  logic             sel_mem_s3_i,
    input  logic             rw_s3_n_i,
    input  logic [ADDR_LEFT:0] waddr_s3_i,
    input  logic [ADDR_LEFT:0] r1_addr_i,
    input  logic [ADDR_LEFT:0] r2_addr_i,
    output logic             hazard_o
);

    logic addr_match;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign addr_match = (waddr_s3_i != '0) &&
                        ((waddr_s3_i == r1_addr_i) || (waddr_s3_i == r2_addr_i));

    assign hazard_o = valid_s3_i & valid_s2_i & sel_mem_s3_i & ~rw_s3_n_i & addr_match;

endmodule

// File: rtl/pipe_id_ex_hs.sv
// ID->EX valid/ready pipeline register with flush, sticky halt lock and an
// optional load-use interlock plus stall counter (define PIPE_ID_EX_HAZARD_EN).
module pipe_id_ex_hs
    import pipe_pkg::*;
#(
    parameter int BITS       = BITS_DEF,
    parameter int REG_WORDS  = REG_WORDS_DEF,
    parameter int ADDR_LEFT  = $clog2(REG_WORDS) - 1,
    parameter int OP_BITS    = OP_BITS_DEF,
    parameter int SHIFT_BITS = SHIFT_BITS_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  valid_s2,
    output logic                  ready_s2,
    input  logic                  flush,
    input  ctl_t                  ctl_s2,
    input  logic [BITS-1:0]       r1_data,
    input  logic [BITS-1:0]       r2_data,
    input  logic [BITS-1:0]       sign_ext_imm,
    input  logic [SHIFT_BITS-1:0] shamt,
    input  logic [ADDR_LEFT:0]    waddr_,
    input  logic [ADDR_LEFT:0]    r1_addr,
    input  logic [ADDR_LEFT:0]    r2_addr,
    output logic                  valid_s3,
    input  logic                  ready_s3,
    output ctl_t                  ctl_s3,
    output logic [BITS-1:0]       r1_data_s3,
    output logic [BITS-1:0]       r2_data_s3,
    output logic [BITS-1:0]       sign_ext_imm_s3,
    output logic [SHIFT_BITS-1:0] shamt_s3,
    output logic [ADDR_LEFT:0]    waddr_s3,
    output logic [ADDR_LEFT:0]    r1_addr_s3,
    output logic [ADDR_LEFT:0]    r2_addr_s3,
    output logic                  hazard,
    output logic [CNT_BITS-1:0]   stall_cnt
);

    // A narrower ALU-op configuration clears the unused upper bits of the field.
    localparam logic [OP_BITS_DEF-1:0] OP_MASK = OP_BITS_DEF'((1 << OP_BITS) - 1);

    logic                  valid_q, valid_d;
    ctl_t                  ctl_q, ctl_d;
    logic                  halt_lock_q, halt_lock_d;
    logic [BITS-1:0]       r1_data_q, r1_data_d;
    logic [BITS-1:0]       r2_data_q, r2_data_d;
    logic [BITS-1:0]       imm_q, imm_d;
    logic [SHIFT_BITS-1:0] shamt_q, shamt_d;
    logic [ADDR_LEFT:0]    waddr_q, waddr_d;
    logic [ADDR_LEFT:0]    r1_addr_q, r1_addr_d;
    logic [ADDR_LEFT:0]    r2_addr_q, r2_addr_d;
    logic                  accept;

    assign ready_s2 = (~valid_q | ready_s3) & ~hazard & ~halt_lock_q;
    assign accept   = valid_s2 & ready_s2;

    always_comb begin
        // NOTE: every target gets a hold default first so no path can infer a latch.
        valid_d     = valid_q;
        ctl_d       = ctl_q;
        r1_data_d   = r1_data_q;
        r2_data_d   = r2_data_q;
        imm_d       = imm_q;
        shamt_d     = shamt_q;
        waddr_d     = waddr_q;
        r1_addr_d   = r1_addr_q;
        r2_addr_d   = r2_addr_q;
        halt_lock_d = halt_lock_q | (accept & ctl_s2.halt);

        if (flush) begin
            valid_d = 1'b0;
            ctl_d   = CTL_BUBBLE;
        end else if (accept) begin
            valid_d       = 1'b1;
            ctl_d         = ctl_s2;
            ctl_d.alu_op  = ctl_s2.alu_op & OP_MASK;
            r1_data_d     = r1_data;
            r2_data_d     = r2_data;
            imm_d         = sign_ext_imm;
            shamt_d       = shamt;
            waddr_d       = waddr_;
            r1_addr_d     = r1_addr;
            r2_addr_d     = r2_addr;
        end else if (~valid_q | ready_s3) begin
            // Word consumed (or never present) with nothing new: drain to a bubble.
            valid_d = 1'b0;
            ctl_d   = CTL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid_q     <= 1'b0;
            ctl_q       <= CTL_BUBBLE;
            halt_lock_q <= 1'b0;
            // NOTE: payload is reset too, so stage-3 outputs read zero right after reset.
            r1_data_q   <= '0;
            r2_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            waddr_q     <= '0;
            r1_addr_q   <= '0;
            r2_addr_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so all state advances from pre-edge values.
            valid_q     <= valid_d;
            ctl_q       <= ctl_d;
            halt_lock_q <= halt_lock_d;
            r1_data_q   <= r1_data_d;
            r2_data_q   <= r2_data_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            waddr_q     <= waddr_d;
            r1_addr_q   <= r1_addr_d;
            r2_addr_q   <= r2_addr_d;
        end
    end

    assign valid_s3        = valid_q;
    assign ctl_s3          = ctl_q;
    assign r1_data_s3      = r1_data_q;
    assign r2_data_s3      = r2_data_q;
    assign sign_ext_imm_s3 = imm_q;
    assign shamt_s3        = shamt_q;
    assign waddr_s3        = waddr_q;
    assign r1_addr_s3      = r1_addr_q;
    assign r2_addr_s3      = r2_addr_q;

`ifdef PIPE_ID_EX_HAZARD_EN
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    load_use_det #(
        .ADDR_LEFT (ADDR_LEFT)
    ) u_load_use_det (
        .valid_s3_i   (valid_q),
        .valid_s2_i   (valid_s2),
        .sel_mem_s3_i (ctl_q.sel_mem),
        .rw_s3_n_i    (ctl_q.rw_),
        .waddr_s3_i   (waddr_q),
        .r1_addr_i    (r1_addr),
        .r2_addr_i    (r2_addr),
        .hazard_o     (hazard)
    );

    // Saturates so a long interlock never wraps back to a small count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_id_ex_hs.sv
// Bench for pipe_id_ex_hs: directed steps plus randomized traffic against a
// one-entry-queue reference model; also probes load_use_det directly.
module tb_pipe_id_ex_hs;
    import pipe_pkg::*;

`ifdef PIPE_ID_EX_HAZARD_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  waddr;
        logic [4:0]  r1a;
        logic [4:0]  r2a;
    } word_t;

    typedef struct packed {
        logic  valid;
        logic  flush;
        logic  ready;
        word_t w;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        valid_s2 = 1'b0;
    logic        flush = 1'b0;
    logic        ready_s3 = 1'b0;
    word_t       in_w = '0;
    logic        ready_s2, valid_s3, hazard;
    ctl_t        ctl_s3;
    logic [31:0] r1_data_s3, r2_data_s3, sign_ext_imm_s3;
    logic [4:0]  shamt_s3, waddr_s3, r1_addr_s3, r2_addr_s3;
    logic [15:0] stall_cnt;
    word_t       obs_word;

    logic        d_v3 = 1'b0, d_v2 = 1'b0, d_sm = 1'b0, d_rwn = 1'b0;
    logic [4:0]  d_wa = '0, d_a1 = '0, d_a2 = '0;
    logic        d_haz;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    word_t       mq[$];
    bit          m_halt;
    int unsigned m_cnt;
    bit          m_haz, m_ready, m_acc;

    pipe_id_ex_hs dut (
        .clk             (clk),
        .rst_            (rst_),
        .valid_s2        (valid_s2),
        .ready_s2        (ready_s2),
        .flush           (flush),
        .ctl_s2          (in_w.ctl),
        .r1_data         (in_w.r1),
        .r2_data         (in_w.r2),
        .sign_ext_imm    (in_w.imm),
        .shamt           (in_w.shamt),
        .waddr_          (in_w.waddr),
        .r1_addr         (in_w.r1a),
        .r2_addr         (in_w.r2a),
        .valid_s3        (valid_s3),
        .ready_s3        (ready_s3),
        .ctl_s3          (ctl_s3),
        .r1_data_s3      (r1_data_s3),
        .r2_data_s3      (r2_data_s3),
        .sign_ext_imm_s3 (sign_ext_imm_s3),
        .shamt_s3        (shamt_s3),
        .waddr_s3        (waddr_s3),
        .r1_addr_s3      (r1_addr_s3),
        .r2_addr_s3      (r2_addr_s3),
        .hazard          (hazard),
        .stall_cnt       (stall_cnt)
    );

    load_use_det #(.ADDR_LEFT(4)) det (
        .valid_s3_i   (d_v3),
        .valid_s2_i   (d_v2),
        .sel_mem_s3_i (d_sm),
        .rw_s3_n_i    (d_rwn),
        .waddr_s3_i   (d_wa),
        .r1_addr_i    (d_a1),
        .r2_addr_i    (d_a2),
        .hazard_o     (d_haz)
    );

    assign obs_word = {ctl_s3, r1_data_s3, r2_data_s3, sign_ext_imm_s3,
                       shamt_s3, waddr_s3, r1_addr_s3, r2_addr_s3};

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load-use rule: a valid register-writing load in stage 3 whose nonzero
    // destination is read by a valid stage-2 word.
    function automatic bit load_use_rule(bit v3, bit v2, bit sel_mem, bit rw_n,
                                         logic [4:0] wa, logic [4:0] a1, logic [4:0] a2);
        return v3 && v2 && sel_mem && !rw_n && (wa != 5'd0) && (wa == a1 || wa == a2);
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w.ctl      = ctl_t'(16'($urandom));
        w.ctl.halt = 1'b0;
        w.r1       = $urandom;
        w.r2       = $urandom;
        w.imm      = $urandom;
        w.shamt    = 5'($urandom);
        w.waddr    = 5'($urandom_range(0, 3));
        w.r1a      = 5'($urandom_range(0, 3));
        w.r2a      = 5'($urandom_range(0, 3));
        return w;
    endfunction

    function automatic word_t base_word();
        word_t w;
        w     = '0;
        w.ctl = CTL_BUBBLE;
        return w;
    endfunction

    task automatic check_regs();
        check("valid_s3", valid_s3, mq.size() != 0);
        if (mq.size() != 0) check("s3_word", obs_word, mq[0]);
        else                check("ctl_s3_bubble", ctl_s3, CTL_BUBBLE);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic drive_comb(input stim_t s);
        bit    sv;
        word_t s3;
        valid_s2 = s.valid;
        flush    = s.flush;
        ready_s3 = s.ready;
        in_w     = s.w;
        #1;
        sv      = (mq.size() != 0);
        s3      = sv ? mq[0] : '0;
        m_haz   = HAZ_EN && load_use_rule(sv, s.valid, s3.ctl.sel_mem, s3.ctl.rw_,
                                          s3.waddr, s.w.r1a, s.w.r2a);
        m_ready = (!sv || s.ready) && !m_haz && !m_halt;
        m_acc   = s.valid && m_ready;
        check("hazard", hazard, m_haz);
        check("ready_s2", ready_s2, m_ready);
    endtask

    task automatic finish_cycle(input stim_t s);
        bit sv;
        sv = (mq.size() != 0);
        if (m_acc && s.w.ctl.halt) m_halt = 1'b1;
        if (m_haz && m_cnt < 32'hFFFF) m_cnt++;
        if (s.flush) mq.delete();
        else if (m_acc) begin
            mq.delete();
            mq.push_back(s.w);
        end else if (!sv || s.ready) mq.delete();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic step(input stim_t s);
        drive_comb(s);
        finish_cycle(s);
    endtask

    task automatic apply_reset();
        word_t rst_w;
        rst_w     = '0;
        rst_w.ctl = CTL_BUBBLE;
        rst_      = 1'b0;
        valid_s2  = 1'b0;
        flush     = 1'b0;
        ready_s3  = 1'b0;
        #1;
        mq.delete();
        m_halt = 1'b0;
        m_cnt  = 0;
        check("rst_valid_s3", valid_s3, 1'b0);
        check("rst_word", obs_word, rst_w);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        #1;
    endtask

    initial begin
        stim_t s;
        word_t w;
        int    n_hold;

        // Reset values.
        #2;
        apply_reset();
        check("rst_ready_s2", ready_s2, 1'b1);
        check("rst_hazard", hazard, 1'b0);

        // Single transfer, latency one.
        w    = base_word();
        w.r1 = 32'hDEADBEEF;
        s    = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        step(s);
        check("xfer_valid_s3", valid_s3, 1'b1);
        check("xfer_r1_data_s3", r1_data_s3, 32'hDEADBEEF);

        // Downstream stall: outputs hold, upstream sees ready low.
        for (int i = 0; i < 3; i++) begin
            s = '{valid: 1'b1, flush: 1'b0, ready: 1'b0, w: rand_word()};
            drive_comb(s);
            check("stall_ready_s2", ready_s2, 1'b0);
            finish_cycle(s);
            check("stall_r1_hold", r1_data_s3, 32'hDEADBEEF);
            check("stall_valid_hold", valid_s3, 1'b1);
        end

        // Load in stage 3 to r5, consumer reads r5 through r2_addr.
        w             = base_word();
        w.ctl.sel_mem = 1'b1;
        w.ctl.rw_     = 1'b0;
        w.waddr       = 5'd5;
        s             = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        step(s);
        w     = base_word();
        w.r1a = 5'd3;
        w.r2a = 5'd5;
        s     = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        drive_comb(s);
        check("lu_hazard", hazard, HAZ_EN);
        check("lu_ready_s2", ready_s2, !HAZ_EN);
        finish_cycle(s);
        check("lu_bubble_valid", valid_s3, !HAZ_EN);
        check("lu_bubble_rw_", ctl_s3.rw_, 1'b1);
        check("lu_stall_cnt", stall_cnt, {15'd0, HAZ_EN});

        // Load to r0 never interlocks.
        w             = base_word();
        w.ctl.sel_mem = 1'b1;
        w.ctl.rw_     = 1'b0;
        w.waddr       = 5'd0;
        s             = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        step(s);
        w = base_word();
        s = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        drive_comb(s);
        check("r0_hazard", hazard, 1'b0);
        check("r0_ready_s2", ready_s2, 1'b1);
        finish_cycle(s);

        // Flush overrides a simultaneous accept.
        s = '{valid: 1'b1, flush: 1'b1, ready: 1'b1, w: rand_word()};
        step(s);
        check("flush_valid_s3", valid_s3, 1'b0);
        check("flush_byte_en", ctl_s3.byte_en, 4'hF);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            s.valid = ($urandom_range(0, 3) != 0);
            s.flush = ($urandom_range(0, 11) == 0);
            s.ready = ($urandom_range(0, 4) < 3);
            s.w     = rand_word();
            step(s);
        end

        // Halt word locks the upstream handshake until reset, flush included.
        w          = base_word();
        w.ctl.halt = 1'b1;
        s          = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        drive_comb(s);
        check("halt_accept", ready_s2, 1'b1);
        finish_cycle(s);
        for (int i = 0; i < 4; i++) begin
            s = '{valid: 1'b1, flush: (i == 1), ready: 1'b1, w: rand_word()};
            drive_comb(s);
            check("halt_lock_ready_s2", ready_s2, 1'b0);
            finish_cycle(s);
        end
        apply_reset();
        s = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: rand_word()};
        drive_comb(s);
        check("halt_cleared_ready_s2", ready_s2, 1'b1);
        finish_cycle(s);

        // Long interlock: counter saturates at all-ones.
        apply_reset();
        w             = base_word();
        w.ctl.sel_mem = 1'b1;
        w.ctl.rw_     = 1'b0;
        w.waddr       = 5'd5;
        s             = '{valid: 1'b1, flush: 1'b0, ready: 1'b1, w: w};
        step(s);
        w     = base_word();
        w.r1a = 5'd5;
        s     = '{valid: 1'b1, flush: 1'b0, ready: 1'b0, w: w};
        n_hold = HAZ_EN ? 65534 : 20;
        for (int i = 0; i < n_hold; i++) step(s);
        check("sat_below_max", stall_cnt, HAZ_EN ? 16'hFFFE : 16'h0000);
        drive_comb(s);
        check("sat_hazard", hazard, HAZ_EN);
        finish_cycle(s);
        check("sat_at_max", stall_cnt, HAZ_EN ? 16'hFFFF : 16'h0000);
        for (int i = 0; i < 5; i++) step(s);
        check("sat_holds", stall_cnt, HAZ_EN ? 16'hFFFF : 16'h0000);

        // Detector on its own, with the load/destination cases biased in.
        for (int i = 0; i < 300; i++) begin
            d_v3  = ($urandom_range(0, 3) != 0);
            d_v2  = ($urandom_range(0, 3) != 0);
            d_sm  = $urandom_range(0, 1) == 1;
            d_rwn = $urandom_range(0, 1) == 1;
            d_wa  = 5'($urandom_range(0, 3));
            d_a1  = 5'($urandom_range(0, 3));
            d_a2  = 5'($urandom_range(0, 3));
            #1;
            check("det_hazard", d_haz, load_use_rule(d_v3, d_v2, d_sm, d_rwn, d_wa, d_a1, d_a2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
